// File: rtl/dest_tag_pipe.sv
// dest_tag_pipe: destination-tag shift pipeline (EX -> MEM -> WB -> RFile)
// with load-use interlock, freeze-safe branch flush and a saturating
// count of applied load-use bubbles.
module dest_tag_pipe #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              freeze,
  input  logic              flush,
  output logic              load_use_stall,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_regwrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] rfile_rd,
  output logic              rfile_regwrite,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  logic [REG_AW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic              ex_regwrite_q, ex_memread_q;
  logic [REG_AW-1:0] mem_rd_q, wb_rd_q, rfile_rd_q;
  logic              mem_regwrite_q, wb_regwrite_q, rfile_regwrite_q;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [REG_AW-1:0] ex_rd_d, ex_rs1_d, ex_rs2_d;
  logic              ex_regwrite_d, ex_memread_d;
  logic              id_writes, id_loads;
  logic              kill, ex_bubble, rs1_hit, rs2_hit;

  // Writes to x0 and empty ID slots must never look like producers downstream.
  assign id_writes = id_valid & id_regwrite & (id_rd != '0);
  assign id_loads  = id_valid & id_memread  & (id_rd != '0);

  assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd_q);
  assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd_q);

  assign load_use_stall = id_valid & ex_memread_q & ex_regwrite_q &
                          (ex_rd_q != '0) & (rs1_hit | rs2_hit);

  // A flush that landed during a freeze is remembered until the pipe moves.
  assign kill      = flush | flush_pend_q;
  assign ex_bubble = kill | load_use_stall;

  // Next EX entry: bubble on kill/stall, otherwise the normalized ID tag.
  always_comb begin
    ex_rd_d       = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    if (!ex_bubble) begin
      ex_rd_d       = id_rd;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_regwrite_d = id_writes;
      ex_memread_d  = id_loads;
    end
  end

  // Pending-flush and saturating stall counter next state; a killed
  // instruction's stall is not counted since the instruction is dead.
  always_comb begin
    flush_pend_d = freeze ? (flush_pend_q | flush) : 1'b0;
    cnt_d        = cnt_q;
    if (!freeze && load_use_stall && !kill && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Tag registers: reset to bubbles, hold on freeze, otherwise shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rd_q          <= '0;
      ex_rs1_q         <= '0;
      ex_rs2_q         <= '0;
      ex_regwrite_q    <= 1'b0;
      ex_memread_q     <= 1'b0;
      mem_rd_q         <= '0;
      mem_regwrite_q   <= 1'b0;
      wb_rd_q          <= '0;
      wb_regwrite_q    <= 1'b0;
      rfile_rd_q       <= '0;
      rfile_regwrite_q <= 1'b0;
    end else if (!freeze) begin
      ex_rd_q          <= ex_rd_d;
      ex_rs1_q         <= ex_rs1_d;
      ex_rs2_q         <= ex_rs2_d;
      ex_regwrite_q    <= ex_regwrite_d;
      ex_memread_q     <= ex_memread_d;
      mem_rd_q         <= ex_rd_q;
      mem_regwrite_q   <= ex_regwrite_q;
      wb_rd_q          <= mem_rd_q;
      wb_regwrite_q    <= mem_regwrite_q;
      rfile_rd_q       <= wb_rd_q;
      rfile_regwrite_q <= wb_regwrite_q;
    end
  end

  // Control state: reset discards any pending flush and clears the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_rs1         = ex_rs1_q;
  assign ex_rs2         = ex_rs2_q;
  assign mem_rd         = mem_rd_q;
  assign mem_regwrite   = mem_regwrite_q;
  assign wb_rd          = wb_rd_q;
  assign wb_regwrite    = wb_regwrite_q;
  assign rfile_rd       = rfile_rd_q;
  assign rfile_regwrite = rfile_regwrite_q;
  assign lu_stall_cnt   = cnt_q;

endmodule

// File: tb/tb_dest_tag_pipe.sv
// Scoreboard bench for dest_tag_pipe (CNT_W=4 build so saturation is reachable).
module tb_dest_tag_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0;
  logic       freeze = 1'b0, flush = 1'b0;
  logic       load_use_stall;
  logic [4:0] ex_rs1, ex_rs2, mem_rd, wb_rd, rfile_rd;
  logic       mem_regwrite, wb_regwrite, rfile_regwrite;
  logic [3:0] lu_stall_cnt;

  dest_tag_pipe #(.REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .freeze(freeze), .flush(flush), .load_use_stall(load_use_stall),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .rfile_rd(rfile_rd),
    .rfile_regwrite(rfile_regwrite), .lu_stall_cnt(lu_stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit [4:0] rd, rs1, rs2; bit rw, mr; } ent_t;
  typedef struct {
    bit stall;
    bit [4:0] ers1, ers2, mrd, wrd, frd;
    bit mrw, wrw, frw;
    int cnt;
  } exp_t;

  ent_t pipe[$];      // [0]=EX [1]=MEM [2]=WB [3]=RFile
  bit   m_fp;
  int   m_cnt;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void chk(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Drive one cycle of ID/control inputs and predict the outcome.
  task automatic step(input bit r, input bit v, input bit [4:0] rd, rs1, rs2,
                      input bit u1, u2, rw, mr, fz, fl);
    exp_t e;
    ent_t ne, bub;
    bit st, kill;
    @(negedge clk);
    rst_n = r; id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = mr;
    freeze = fz; flush = fl;
    bub = '{default: 0};
    st = v && pipe[0].mr && pipe[0].rw && (pipe[0].rd != 0) &&
         ((u1 && rs1 == pipe[0].rd) || (u2 && rs2 == pipe[0].rd));
    e.stall = st;
    if (!r) begin
      pipe = '{bub, bub, bub, bub};
      m_fp = 0;
      m_cnt = 0;
    end else if (fz) begin
      m_fp = m_fp | fl;
    end else begin
      kill = fl || m_fp;
      if (kill || st) ne = bub;
      else ne = '{rd, rs1, rs2, rw && v && rd != 0, mr && v && rd != 0};
      if (st && !kill && m_cnt < 15) m_cnt++;
      pipe.push_front(ne);
      void'(pipe.pop_back());
      m_fp = 0;
    end
    e.ers1 = pipe[0].rs1; e.ers2 = pipe[0].rs2;
    e.mrd = pipe[1].rd; e.mrw = pipe[1].rw;
    e.wrd = pipe[2].rd; e.wrw = pipe[2].rw;
    e.frd = pipe[3].rd; e.frw = pipe[3].rw;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: stall sampled just before the edge, tags just after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("load_use_stall", int'(load_use_stall), int'(e.stall));
        @(posedge clk);
        #1;
        chk("ex_rs1", int'(ex_rs1), int'(e.ers1));
        chk("ex_rs2", int'(ex_rs2), int'(e.ers2));
        chk("mem_rd", int'(mem_rd), int'(e.mrd));
        chk("mem_regwrite", int'(mem_regwrite), int'(e.mrw));
        chk("wb_rd", int'(wb_rd), int'(e.wrd));
        chk("wb_regwrite", int'(wb_regwrite), int'(e.wrw));
        chk("rfile_rd", int'(rfile_rd), int'(e.frd));
        chk("rfile_regwrite", int'(rfile_regwrite), int'(e.frw));
        chk("lu_stall_cnt", int'(lu_stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, v, fz, fl;
    pipe = '{'{default: 0}, '{default: 0}, '{default: 0}, '{default: 0}};
    m_fp = 0;
    m_cnt = 0;

    // Reset, then single write to x5 walking down the pipe.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 2, 0, 0, 1, 0, 0, 0);
    nop(6);

    // Load x7 then dependent use of rs2=7 (held in ID for the stall cycle).
    step(1, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 8, 1, 7, 0, 1, 1, 0, 0, 0);
    step(1, 1, 8, 1, 7, 0, 1, 1, 0, 0, 0);
    nop(2);
    @(posedge clk); #1;
    chk("lu_cnt_after_one_stall", int'(lu_stall_cnt), 1);

    // Same pair without use_rs2: no stall.
    step(1, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 8, 1, 7, 0, 0, 1, 0, 0, 0);
    nop(3);

    // Load to x0 followed by a use of x0.
    step(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 9, 0, 0, 1, 1, 1, 0, 0, 0);
    nop(3);

    // Flush on the first of three frozen cycles, applied when unfrozen.
    step(1, 1, 4, 2, 3, 1, 1, 1, 0, 0, 0);
    step(1, 1, 6, 3, 4, 1, 1, 1, 0, 1, 1);
    step(1, 1, 6, 3, 4, 1, 1, 1, 0, 1, 0);
    step(1, 1, 6, 3, 4, 1, 1, 1, 0, 1, 0);
    step(1, 1, 6, 3, 4, 1, 1, 1, 0, 0, 0);
    nop(4);

    // Flush together with a load-use hazard, unfrozen and then frozen.
    step(1, 1, 3, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 10, 3, 0, 1, 0, 1, 0, 0, 1);
    step(1, 1, 3, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 1, 10, 3, 0, 1, 0, 1, 0, 1, 1);
    step(1, 1, 10, 3, 0, 1, 0, 1, 0, 1, 0);
    step(1, 1, 10, 3, 0, 1, 0, 1, 0, 0, 0);
    nop(4);

    // Drive the 4-bit counter into saturation.
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
      step(1, 1, 2, 1, 0, 1, 0, 1, 0, 0, 0);
    end
    nop(2);
    @(posedge clk); #1;
    chk("lu_cnt_saturated", int'(lu_stall_cnt), 15);

    // Reset mid-freeze with a pending flush, then random traffic.
    step(1, 1, 4, 0, 0, 0, 0, 1, 0, 1, 1);
    step(0, 1, 4, 0, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 59) != 0);
      v  = ($urandom_range(0, 4) != 0);
      fz = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(r, v, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), fz, fl);
    end
    nop(1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
